// File: rtl/mul_div_unit.sv
// Iterative RV32M-class multiply/divide unit for the execute stage.
// Multiply is shift-add (or one registered product when FAST_MUL != 0).
// Divide is restoring, one quotient bit per cycle, MSB first.
// Signed operations run on magnitudes; the sign is applied on the final cycle.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | iterating, busy high
// DONE  | result valid for one cycle, done high
module mul_div_unit #(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, hi_q, lo_q;
  logic              neg_q, neg_r_q;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   result_q;

  logic              sgn1, sgn2, special;
  logic [XLEN-1:0]   mag1, mag2, special_res;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [XLEN-1:0]   hi_d, lo_d, quo, rem, final_d;
  logic [2*XLEN-1:0] prod_raw, prod_fix;

  // Decode the incoming request: operand signedness, magnitudes, bypass cases.
  always_comb begin
    sgn1 = rs1[XLEN-1] & (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
    sgn2 = rs2[XLEN-1] & (op == 3'b001 || op == 3'b100 || op == 3'b110);
    mag1 = sgn1 ? -rs1 : rs1;
    mag2 = sgn2 ? -rs2 : rs2;
    special = op[2] & ((rs2 == '0) |
                       (~op[0] & (rs1 == MOST_NEG) & (rs2 == {XLEN{1'b1}})));
    if (rs2 == '0) special_res = op[1] ? rs1 : {XLEN{1'b1}};
    else           special_res = op[1] ? {XLEN{1'b0}} : rs1;
  end

  // One iteration step plus the sign-corrected result of the final step.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, a_q};
    if (op_q[2]) begin
      if (!div_diff[XLEN]) begin
        hi_d = div_diff[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_d = div_shift[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[XLEN:1];
      lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    // In single-stage mode lo_q still holds the multiplier magnitude.
    prod_raw = (FAST_MUL != 0) ? ({{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, lo_q})
                               : {hi_d, lo_d};
    prod_fix = neg_q ? -prod_raw : prod_raw;
    quo      = neg_q ? -lo_d : lo_d;
    rem      = neg_r_q ? -hi_d : hi_d;
    case (op_q)
      3'b000:                 final_d = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_d = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_d = quo;
      default:                final_d = rem;
    endcase
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_CALC: begin
          hi_q <= hi_d;
          lo_q <= lo_d;
          if (cnt_q == '0) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= final_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (start) begin
            op_q    <= op;
            hi_q    <= '0;
            neg_q   <= sgn1 ^ sgn2;
            neg_r_q <= sgn1;
            // Divide keeps the divisor in a_q and shifts the dividend out of lo_q.
            a_q     <= op[2] ? mag2 : mag1;
            lo_q    <= op[2] ? mag1 : mag2;
            if (special) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= special_res;
            end else begin
              state_q <= S_CALC;
              busy_q  <= 1'b1;
              cnt_q   <= ((FAST_MUL != 0) && !op[2]) ? '0 : CNT_LOAD;
            end
          end
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
